// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared widths and FSM state encodings for the UART TX scheduler
package uart_sched_pkg;
  localparam int NREQ_MAX = 8;
  localparam int BYTE_W = 8;
  localparam int IW = $clog2(NREQ_MAX);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_SEND = 3'd3;
  localparam logic [2:0] S_GAP = 3'd4;
endpackage

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: requester-side request/ack/grant bundle of the UART TX scheduler
interface uart_tx_scheduler_if import uart_sched_pkg::*; #(parameter int NREQ = 4);
  logic [NREQ-1:0] req;
  logic [NREQ*BYTE_W-1:0] req_data;
  logic [NREQ-1:0] req_last;
  logic [NREQ-1:0] ack;
  logic [NREQ-1:0] grant;
  modport master(output req, req_data, req_last, input ack, grant);
  modport slave(input req, req_data, req_last, output ack, grant);
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first requester after ptr wins
module rr_arbiter import uart_sched_pkg::*; #(parameter int NREQ = 4) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx
);
  logic [NREQ-1:0] rot;
  always_comb begin
    rot = NREQ'({req, req} >> (int'(ptr) + 1));
    idx = '0;
    for (int j = NREQ - 1; j >= 0; j--)
      if (rot[j]) idx = IW'((int'(ptr) + 1 + j) % NREQ);
  end
  assign gnt = |req ? {{(NREQ-1){1'b0}}, 1'b1} << idx : '0;
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: message-granular round-robin sharing of one UART transmitter
module uart_tx_scheduler import uart_sched_pkg::*; #(
  parameter int NREQ = 4,
  parameter int MAX_BYTES = 16,
  parameter int GAP_TICKS = 2
) (
  input  logic              CLKIN,
  input  logic              RESET,
  input  logic              baud_tick,
  uart_tx_scheduler_if.slave bus,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_run,
  input  logic              tx_done,
  output logic              busy,
  output logic              forced
);
  logic [2:0] state;
  logic [NREQ-1:0] grant, ack, arb_gnt;
  logic [IW-1:0] owner, ptr, arb_idx;
  logic [7:0] cnt;
  logic [3:0] gap;
  logic last_f, fell, own_req, own_last;
  logic [BYTE_W-1:0] own_data;
  rr_arbiter #(.NREQ(NREQ)) u_arb (.req(bus.req), .ptr(ptr), .gnt(arb_gnt), .idx(arb_idx));
  always_comb begin
    own_data = '0;
    own_last = 1'b0;
    for (int j = 0; j < NREQ; j++)
      if (grant[j]) begin
        own_data = bus.req_data[j*BYTE_W +: BYTE_W];
        own_last = bus.req_last[j];
      end
  end
  assign own_req = |(bus.req & grant);
  assign busy = state != S_IDLE;
  assign bus.ack = ack;
  assign bus.grant = grant;
  // SEND waits for done to drop and rise again, so a transmitter that lowers done a tick late still works
  always_ff @(posedge CLKIN) begin
    if (RESET) begin
      state <= S_IDLE;
      grant <= '0;
      ack <= '0;
      owner <= '0;
      ptr <= '0;
      cnt <= '0;
      gap <= '0;
      last_f <= 1'b0;
      fell <= 1'b0;
      tx_data <= '0;
      tx_run <= 1'b0;
      forced <= 1'b0;
    end else begin
      ack <= '0;
      forced <= 1'b0;
      case (state)
        S_IDLE: if (|bus.req) begin
          grant <= arb_gnt;
          owner <= arb_idx;
          state <= S_LOAD;
        end
        S_LOAD: if (own_req) begin
          tx_data <= own_data;
          last_f <= own_last;
          ack <= grant;
          tx_run <= 1'b1;
          cnt <= cnt + 8'd1;
          state <= S_START;
        end
        S_START: if (baud_tick && tx_done) begin
          tx_run <= 1'b0;
          fell <= 1'b0;
          state <= S_SEND;
        end
        S_SEND: begin
          if (!tx_done) fell <= 1'b1;
          if (fell && tx_done) begin
            if (last_f || cnt == 8'(MAX_BYTES)) begin
              grant <= '0;
              ptr <= owner;
              cnt <= '0;
              gap <= '0;
              forced <= !last_f;
              state <= S_GAP;
            end else state <= S_LOAD;
          end
        end
        S_GAP: begin
          if (GAP_TICKS == 0 || (baud_tick && gap == 4'(GAP_TICKS - 1))) state <= S_IDLE;
          else if (baud_tick) gap <= gap + 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: scoreboard bench with a message-level arbitration model and a behavioural transmitter
module tb_uart_tx_scheduler;
  localparam int NREQ = 4;
  localparam int MAX_B = 3;
  localparam int GAP = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic baud_tick = 1'b0;
  logic [7:0] tx_data;
  logic tx_run, busy, forced;
  logic tx_done = 1'b1;
  uart_tx_scheduler_if #(.NREQ(NREQ)) bus ();
  uart_tx_scheduler #(.NREQ(NREQ), .MAX_BYTES(MAX_B), .GAP_TICKS(GAP)) dut (
    .CLKIN(clk), .RESET(rst), .baud_tick(baud_tick), .bus(bus),
    .tx_data(tx_data), .tx_run(tx_run), .tx_done(tx_done), .busy(busy), .forced(forced));
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  logic [8:0] rq [NREQ][$];
  logic [8:0] mq [NREQ][$];
  logic [10:0] exp_ack [$];
  logic [7:0] exp_frame [$];
  logic [7:0] tx_frames [$];
  int mptr = 0, exp_forced = 0, forced_cnt = 0, ignored = 0;
  logic ignore = 1'b0, rnd_stall = 1'b0;
  logic [NREQ-1:0] hold = '0;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  int bcnt = 0;
  always @(negedge clk) begin
    bcnt = (bcnt + 1) % 8;
    baud_tick = bcnt == 0;
  end
  int tx_st = 0, tx_bits = 0;
  logic [7:0] tx_sh;
  always @(posedge clk) if (baud_tick) begin
    if (tx_st == 0 && tx_run && tx_done) begin
      tx_sh <= tx_data;
      tx_st <= 1;
    end else if (tx_st == 1) begin
      tx_done <= 1'b0;
      tx_bits <= 9;
      tx_st <= 2;
    end else if (tx_st == 2) begin
      if (tx_bits == 0) begin
        tx_done <= 1'b1;
        tx_st <= 0;
        tx_frames.push_back(tx_sh);
      end else tx_bits <= tx_bits - 1;
    end
  end
  logic [NREQ-1:0] r_v, l_v;
  logic [NREQ*8-1:0] d_v;
  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (bus.ack[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      r_v[i] = rq[i].size() > 0 && !hold[i] && !(rnd_stall && bus.grant[i] && $urandom_range(3) == 0);
      d_v[i*8 +: 8] = rq[i].size() > 0 ? rq[i][0][7:0] : 8'h00;
      l_v[i] = rq[i].size() > 0 && rq[i][0][8];
    end
    bus.req = r_v;
    bus.req_data = d_v;
    bus.req_last = l_v;
  end
  logic [NREQ-1:0] prev_grant = '0;
  logic in_gap = 1'b0;
  int gticks = 0;
  initial forever begin
    logic [10:0] e;
    @(posedge clk);
    #1;
    if (rst) begin
      in_gap = 1'b0;
      prev_grant = '0;
    end else if (ignore) begin
      while (tx_frames.size() > 0) begin
        void'(tx_frames.pop_front());
        ignored++;
      end
      prev_grant = bus.grant;
    end else begin
      if (bus.ack != 0) begin
        if (exp_ack.size() == 0) chk("ack_unexpected", 32'(bus.ack), 0);
        else begin
          e = exp_ack.pop_front();
          chk("ack_idx", 32'(bus.ack), 32'(1) << e[10:8]);
          chk("ack_byte", 32'(tx_data), 32'(e[7:0]));
          chk("ack_with_run", 32'(tx_run), 1);
          chk("ack_owner", 32'(bus.ack & ~bus.grant), 0);
          chk("ack_req", 32'(bus.ack & ~bus.req), 0);
        end
      end
      while (tx_frames.size() > 0) begin
        if (exp_frame.size() == 0) chk("frame_unexpected", 32'(tx_frames.pop_front()), 32'hffff);
        else chk("frame", 32'(tx_frames.pop_front()), 32'(exp_frame.pop_front()));
      end
      if (forced) forced_cnt++;
      if (prev_grant != 0 && bus.grant == 0) begin
        in_gap = 1'b1;
        gticks = 0;
      end else if (in_gap) begin
        if (baud_tick) gticks++;
        if (!busy) begin
          chk("gap_ticks", gticks, GAP);
          in_gap = 1'b0;
        end
      end
      prev_grant = bus.grant;
    end
  end
  task automatic put(input int i, input logic [7:0] b, input logic last, input bit stim);
    mq[i].push_back({last, b});
    if (stim) rq[i].push_back({last, b});
  endtask
  task automatic model_run();
    int w, n;
    logic [8:0] e;
    forever begin
      w = -1;
      for (int k = 1; k <= NREQ; k++)
        if (w < 0 && mq[(mptr + k) % NREQ].size() > 0) w = (mptr + k) % NREQ;
      if (w < 0) break;
      n = 0;
      do begin
        e = mq[w].pop_front();
        n++;
        exp_ack.push_back({3'(w), e[7:0]});
        exp_frame.push_back(e[7:0]);
      end while (!e[8] && n < MAX_B && mq[w].size() > 0);
      if (!e[8] && n == MAX_B) exp_forced++;
      mptr = w;
    end
  endtask
  function automatic bit rq_empty();
    for (int i = 0; i < NREQ; i++) if (rq[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction
  task automatic wait_batch();
    int t = 0;
    while (t < 20000 && !(rq_empty() && exp_frame.size() == 0 && !busy)) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("batch_done", 32'(t < 20000), 1);
    chk("acks_left", exp_ack.size(), 0);
    chk("forced_count", forced_cnt, exp_forced);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int t;
    bus.req = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    repeat (3) cyc();
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_tx_run", 32'(tx_run), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_forced", 32'(forced), 0);
    chk("rst_tx_data", 32'(tx_data), 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();
    put(0, 8'h48, 1'b0, 1);
    put(0, 8'h69, 1'b1, 1);
    model_run();
    wait_batch();
    for (int i = 0; i < NREQ; i++) put(i, 8'h30 + 8'(i), 1'b1, 1);
    model_run();
    wait_batch();
    put(1, 8'h11, 1'b1, 1);
    model_run();
    wait_batch();
    for (int k = 0; k < 5; k++) put(2, 8'hC0 + 8'(k), k == 4, 1);
    put(1, 8'h5A, 1'b1, 1);
    model_run();
    wait_batch();
    put(3, 8'h33, 1'b1, 1);
    model_run();
    wait_batch();
    for (int k = 0; k < 3; k++) put(0, 8'h70 + 8'(k), k == 2, 1);
    put(3, 8'hE3, 1'b0, 0);
    put(3, 8'hE4, 1'b1, 0);
    model_run();
    t = 0;
    while (t < 2000 && bus.grant != 4'b0001) begin cyc(); t++; end
    chk("grant0_wait", 32'(t < 2000), 1);
    rq[3].push_back({1'b0, 8'hE3});
    rq[3].push_back({1'b1, 8'hE4});
    wait_batch();
    put(0, 8'hA0, 1'b0, 1);
    put(0, 8'hA1, 1'b1, 1);
    put(1, 8'hB1, 1'b1, 1);
    put(2, 8'hC2, 1'b1, 1);
    model_run();
    t = 0;
    while (t < 2000 && bus.ack[0] !== 1'b1) begin cyc(); t++; end
    chk("stall_first_ack", 32'(t < 2000), 1);
    hold[0] = 1'b1;
    t = 0;
    while (t < 2000 && tx_done) begin cyc(); t++; end
    while (t < 2000 && !tx_done) begin cyc(); t++; end
    chk("stall_reach_load", 32'(t < 2000), 1);
    repeat (2) cyc();
    repeat (20) begin
      cyc();
      chk("stall_hold", 32'({bus.grant, bus.ack, tx_run}), 32'({4'b0001, 4'b0000, 1'b0}));
    end
    hold[0] = 1'b0;
    wait_batch();
    rnd_stall = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < NREQ; i++)
        if ($urandom_range(1) == 1) begin
          int len = $urandom_range(5, 1);
          for (int k = 0; k < len; k++) put(i, 8'($urandom), k == len - 1, 1);
        end
      model_run();
      wait_batch();
    end
    rnd_stall = 1'b0;
    ignore = 1'b1;
    ignored = 0;
    for (int k = 0; k < 3; k++) rq[0].push_back({k == 2, 8'h90 + 8'(k)});
    t = 0;
    while (t < 2000 && !(bus.grant == 4'b0001 && !tx_done)) begin cyc(); t++; end
    chk("rst_mid_send_wait", 32'(t < 2000), 1);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("rst_send_grant", 32'(bus.grant), 0);
    chk("rst_send_tx_run", 32'(tx_run), 0);
    chk("rst_send_busy", 32'(busy), 0);
    chk("rst_send_ack", 32'(bus.ack), 0);
    for (int i = 0; i < NREQ; i++) rq[i].delete();
    @(negedge clk);
    rst = 1'b0;
    t = 0;
    while (t < 2000 && !tx_done) begin cyc(); t++; end
    repeat (200) cyc();
    chk("rst_frames_finished", ignored, 1);
    chk("rst_idle_after", 32'(busy), 0);
    ignore = 1'b0;
    mptr = 0;
    put(0, 8'hD0, 1'b1, 1);
    put(1, 8'hD1, 1'b1, 1);
    model_run();
    wait_batch();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
